// File: rtl/pcileech_com_tx_arbiter_pkg.sv
// pcileech_com_arb_pkg: shared types and constants for the upstream TX arbiter.
package pcileech_com_arb_pkg;
    localparam int ARB_DATA_W = 32;
    localparam logic [2:0] SRC_CFG  = 3'd0;
    localparam logic [2:0] SRC_TLP  = 3'd1;
    localparam logic [2:0] SRC_CORE = 3'd2;
    typedef enum logic {ARB_IDLE, ARB_XFER} arb_state_t;
    typedef struct packed {
        logic [ARB_DATA_W-1:0] data;
        logic                  last;
        logic [2:0]            src;
    } tx_word_t;
endpackage

// File: rtl/pcileech_com_tx_arbiter_if.sv
// pcileech_com_tx_arbiter_if: producer streams, COM-side output and status of the TX arbiter.
interface pcileech_com_tx_arbiter_if #(
    parameter int NUM_SRC = 3,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
);
    logic [NUM_SRC-1:0]        src_en;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_last;
    logic [NUM_SRC-1:0]        src_ready;
    logic                      tx_valid;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_last;
    logic [2:0]                tx_src;
    logic                      tx_ready;
    logic [NUM_SRC-1:0]        grant;
    logic [NUM_SRC-1:0]        err_timeout;
    logic [NUM_SRC*CNT_W-1:0]  pkt_cnt;
    modport slave (
        input  src_en, src_valid, src_data, src_last, tx_ready,
        output src_ready, tx_valid, tx_data, tx_last, tx_src, grant, err_timeout, pkt_cnt
    );
    modport master (
        output src_en, src_valid, src_data, src_last, tx_ready,
        input  src_ready, tx_valid, tx_data, tx_last, tx_src, grant, err_timeout, pkt_cnt
    );
endinterface

// File: rtl/pcileech_com_tx_arbiter_skid2.sv
// pcileech_skid2: 2-entry valid/ready skid buffer; output is driven straight from flops.
module pcileech_skid2
    import pcileech_com_arb_pkg::*;
#(
    parameter type T = tx_word_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);
    T           mem_q [2];
    logic [1:0] cnt_q;
    logic       wp_q, rp_q, push, pop;
    assign in_ready_o  = cnt_q != 2'd2;
    assign out_valid_o = cnt_q != 2'd0;
    assign out_data_o  = mem_q[rp_q];
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            cnt_q    <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wp_q] <= in_data_i;
                wp_q        <= ~wp_q;
            end
            if (pop) rp_q <= ~rp_q;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
endmodule

// File: rtl/pcileech_com_tx_arbiter.sv
// pcileech_com_tx_arbiter: packet-atomic round-robin arbiter feeding the FT601 upstream word path.
module pcileech_com_tx_arbiter
    import pcileech_com_arb_pkg::*;
#(
    parameter int NUM_SRC       = 3,
    parameter int DATA_W        = ARB_DATA_W,
    parameter int STALL_TIMEOUT = 1024,
    parameter int CNT_W         = 16
) (
    input logic clk,
    input logic rst_n,
    pcileech_com_tx_arbiter_if.slave bus
);
    localparam int TMO_W = $clog2(STALL_TIMEOUT);
    arb_state_t         state_q;
    logic [NUM_SRC-1:0] grant_q, err_q, req, rot;
    logic [2:0]         gidx_q, rr_q, nxt_rr, off, pick;
    logic [3:0]         sum;
    logic [TMO_W-1:0]   tmo_q;
    logic [CNT_W-1:0]   cnt_q [NUM_SRC];
    logic               found, in_valid, in_ready, acc;
    tx_word_t           in_w, out_w;
    assign req    = bus.src_valid & bus.src_en;
    assign nxt_rr = gidx_q == 3'(NUM_SRC - 1) ? 3'd0 : gidx_q + 3'd1;
    // Rotate requests so bit 0 is the rr pointer; lowest set bit is the winner offset.
    always_comb begin
        rot   = NUM_SRC'({req, req} >> rr_q);
        found = |req;
        off   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) off = rot[k] ? 3'(k) : off;
        sum  = {1'b0, rr_q} + {1'b0, off};
        pick = sum >= 4'(NUM_SRC) ? 3'(sum - 4'(NUM_SRC)) : sum[2:0];
    end
    always_comb begin
        in_valid = 1'b0;
        in_w     = '0;
        for (int k = 0; k < NUM_SRC; k++)
            if (grant_q[k]) begin
                in_valid = bus.src_valid[k];
                in_w     = '{data: bus.src_data[k*DATA_W +: DATA_W], last: bus.src_last[k], src: 3'(k)};
            end
    end
    assign acc           = in_valid & in_ready;
    assign bus.src_ready = in_ready ? grant_q : '0;
    // Timeout only counts cycles where the owner has nothing to offer; a full skid is not a stall.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            rr_q    <= '0;
            tmo_q   <= '0;
            err_q   <= '0;
            for (int k = 0; k < NUM_SRC; k++) cnt_q[k] <= '0;
        end else begin
            err_q <= '0;
            if (state_q == ARB_IDLE) begin
                if (found) begin
                    state_q <= ARB_XFER;
                    grant_q <= NUM_SRC'(1) << pick;
                    gidx_q  <= pick;
                    tmo_q   <= '0;
                end
            end else if (acc) begin
                tmo_q <= '0;
                if (in_w.last) begin
                    state_q <= ARB_IDLE;
                    grant_q <= '0;
                    rr_q    <= nxt_rr;
                    for (int k = 0; k < NUM_SRC; k++)
                        if (grant_q[k]) cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                end
            end else if (!in_valid) begin
                if (tmo_q == TMO_W'(STALL_TIMEOUT - 1)) begin
                    state_q <= ARB_IDLE;
                    grant_q <= '0;
                    rr_q    <= nxt_rr;
                    err_q   <= grant_q;
                end else tmo_q <= tmo_q + TMO_W'(1);
            end
        end
    pcileech_skid2 #(.T(tx_word_t)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_w),
        .out_valid_o(bus.tx_valid),
        .out_ready_i(bus.tx_ready),
        .out_data_o (out_w)
    );
    assign bus.tx_data     = out_w.data;
    assign bus.tx_last     = out_w.last;
    assign bus.tx_src      = out_w.src;
    assign bus.grant       = grant_q;
    assign bus.err_timeout = err_q;
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
        assign bus.pkt_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
endmodule

// File: tb/tb_pcileech_com_tx_arbiter.sv
// tb_pcileech_com_tx_arbiter: scenario tasks plus a scoreboard of expected output words.
module tb_pcileech_com_tx_arbiter;
    import pcileech_com_arb_pkg::*;
    localparam int N = 3, DW = 32, ST = 8;
    // Counter narrowed to 8 bits so the wrap and the all-ones-before-reset case are reachable quickly.
    localparam int CW = 8;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    pcileech_com_tx_arbiter_if #(.NUM_SRC(N), .DATA_W(DW), .CNT_W(CW)) bus ();
    pcileech_com_tx_arbiter #(.NUM_SRC(N), .DATA_W(DW), .STALL_TIMEOUT(ST), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    int checks = 0, passes = 0, occ = 0, tr_mode = 0, tr_cyc = 0;
    logic [3:0] tr_pat = 4'b1001;
    tx_word_t src_q [N][$];
    tx_word_t exp_q [$];
    logic [N-1:0] acc_s;
    logic pop_s;

    // Source/sink driver: presents queue heads, pops on handshake, tracks skid occupancy.
    always begin
        for (int i = 0; i < N; i++) begin
            bus.src_valid[i]          = src_q[i].size() > 0;
            bus.src_data[i*DW +: DW]  = src_q[i].size() > 0 ? src_q[i][0].data : '0;
            bus.src_last[i]           = src_q[i].size() > 0 ? src_q[i][0].last : 1'b0;
        end
        bus.tx_ready = tr_mode == 0 ? 1'b1 : tr_mode == 2 ? 1'b0 :
                       tr_cyc < 4 ? tr_pat[tr_cyc] : 1'($urandom_range(0, 1));
        tr_cyc++;
        @(negedge clk);
        acc_s = bus.src_valid & bus.src_ready;
        pop_s = bus.tx_valid & bus.tx_ready;
        @(posedge clk);
        #1;
        if (rst_n) begin
            for (int i = 0; i < N; i++) if (acc_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            occ += $countones(acc_s) - int'(pop_s);
        end
    end

    always @(negedge clk)
        if (rst_n && bus.tx_valid && bus.tx_ready) begin
            tx_word_t e;
            checks++;
            if (exp_q.size() == 0)
                $display("FAIL sb_extra: got data=%h last=%b src=%0d, required no word", bus.tx_data, bus.tx_last, bus.tx_src);
            else begin
                e = exp_q.pop_front();
                if ({bus.tx_data, bus.tx_last, bus.tx_src} !== e)
                    $display("FAIL sb_word: got %h/%b/%0d, required %h/%b/%0d", bus.tx_data, bus.tx_last, bus.tx_src, e.data, e.last, e.src);
                else passes++;
            end
        end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        occ = 0;
        tr_mode = 0;
        bus.src_en = '1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic tx_word_t mk(int s, int p, int w, bit l);
        return '{data: {8'(s), 8'(p), 16'(w)}, last: l, src: 3'(s)};
    endfunction

    task automatic send(int s, int p, int len, bit lst);
        for (int w = 0; w < len; w++) src_q[s].push_back(mk(s, p, w, lst && w == len - 1));
    endtask

    task automatic expect_pkt(int s, int p, int len, bit lst);
        for (int w = 0; w < len; w++) exp_q.push_back(mk(s, p, w, lst && w == len - 1));
    endtask

    task automatic drain(int limit, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
                exp_q.size() == 0 && !bus.tx_valid && bus.grant == '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({bus.tx_valid, bus.tx_last, bus.tx_src, bus.tx_data} !== '0)
            $display("FAIL rst_tx: got v=%b l=%b s=%0d d=%h, required all 0", bus.tx_valid, bus.tx_last, bus.tx_src, bus.tx_data);
        else passes++;
        checks++;
        if ({bus.src_ready, bus.grant, bus.err_timeout} !== '0)
            $display("FAIL rst_ctl: got rdy=%b gnt=%b err=%b, required 0", bus.src_ready, bus.grant, bus.err_timeout);
        else passes++;
        checks++;
        if (bus.pkt_cnt !== '0) $display("FAIL rst_cnt: got %h, required 0", bus.pkt_cnt);
        else passes++;
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        send(1, 0, 4, 1);
        expect_pkt(1, 0, 4, 1);
        @(negedge clk);
        checks++;
        if (bus.grant !== 3'b000) $display("FAIL single_n: got grant %b, required 000", bus.grant);
        else passes++;
        @(negedge clk);
        checks++;
        if ({bus.grant, bus.tx_valid} !== 4'b0100) $display("FAIL single_n1: got grant %b txv %b, required 010 0", bus.grant, bus.tx_valid);
        else passes++;
        @(negedge clk);
        checks++;
        if ({bus.tx_valid, bus.tx_src} !== {1'b1, SRC_TLP}) $display("FAIL single_n2: got txv %b src %0d, required 1 1", bus.tx_valid, bus.tx_src);
        else passes++;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.tx_valid, bus.tx_last} !== 2'b10) $display("FAIL single_n4: got v/l %b%b, required 10", bus.tx_valid, bus.tx_last);
        else passes++;
        @(negedge clk);
        checks++;
        if ({bus.tx_valid, bus.tx_last} !== 2'b11) $display("FAIL single_n5: got v/l %b%b, required 11", bus.tx_valid, bus.tx_last);
        else passes++;
        drain(20, ok);
        checks++;
        if (!ok || bus.pkt_cnt[CW +: CW] !== 8'd1) $display("FAIL single_cnt: got drained=%b cnt1=%0d, required 1 1", ok, bus.pkt_cnt[CW +: CW]);
        else passes++;
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N; s++) begin
                send(s, r, 2, 1);
                expect_pkt(s, r, 2, 1);
            end
        drain(60, ok);
        checks++;
        if (!ok || bus.pkt_cnt !== {3{8'd2}}) $display("FAIL rr_cnt: got drained=%b cnt=%h, required 1 020202", ok, bus.pkt_cnt);
        else passes++;
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        tr_cyc = 0;
        tr_mode = 1;
        send(SRC_CFG, 5, 16, 1);
        expect_pkt(SRC_CFG, 5, 16, 1);
        for (int c = 0; c < 300 && (src_q[0].size() != 0 || exp_q.size() != 0); c++) begin
            @(negedge clk);
            if (bus.grant[0]) begin
                checks++;
                if (bus.src_ready[0] !== (occ != 2)) $display("FAIL bp_ready: got rdy %b with %0d held, required %b", bus.src_ready[0], occ, occ != 2);
                else passes++;
            end
        end
        tr_mode = 0;
        drain(40, ok);
        checks++;
        if (!ok || bus.pkt_cnt[0 +: CW] !== 8'd1) $display("FAIL bp_done: got drained=%b cnt0=%0d, required 1 1", ok, bus.pkt_cnt[0 +: CW]);
        else passes++;
    endtask

    task automatic test_timeout();
        bit ok, seen;
        do_reset();
        send(SRC_CORE, 1, 2, 0);
        expect_pkt(SRC_CORE, 1, 2, 0);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = bus.grant == 3'b100;
        end
        send(SRC_CFG, 2, 2, 1);
        expect_pkt(SRC_CFG, 2, 2, 1);
        for (int c = 0; c < 10 && seen; c++) begin
            if (bus.src_valid[2] && bus.src_ready[2] && src_q[2].size() == 1) break;
            @(negedge clk);
        end
        checks++;
        if (!seen) $display("FAIL tmo_grant: got grant %b, required 100", bus.grant);
        else passes++;
        for (int k = 1; k <= ST; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.err_timeout, bus.grant} !== 6'b000100) $display("FAIL tmo_wait%0d: got err %b grant %b, required 000 100", k, bus.err_timeout, bus.grant);
            else passes++;
        end
        @(negedge clk);
        checks++;
        if ({bus.err_timeout, bus.grant} !== 6'b100000) $display("FAIL tmo_pulse: got err %b grant %b, required 100 000", bus.err_timeout, bus.grant);
        else passes++;
        @(negedge clk);
        checks++;
        if ({bus.err_timeout, bus.grant} !== 6'b000001) $display("FAIL tmo_next: got err %b grant %b, required 000 001", bus.err_timeout, bus.grant);
        else passes++;
        drain(20, ok);
        checks++;
        if (!ok || bus.pkt_cnt !== {8'd0, 8'd0, 8'd1}) $display("FAIL tmo_cnt: got drained=%b cnt=%h, required 1 000001", ok, bus.pkt_cnt);
        else passes++;
    endtask

    task automatic test_enable();
        bit ok, seen;
        do_reset();
        bus.src_en = 3'b110;
        send(SRC_CFG, 3, 3, 1);
        send(SRC_TLP, 3, 3, 1);
        expect_pkt(SRC_TLP, 3, 3, 1);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = bus.grant != '0;
        end
        checks++;
        if (bus.grant !== 3'b010) $display("FAIL en_grant: got %b, required 010", bus.grant);
        else passes++;
        @(negedge clk);
        bus.src_en = 3'b100;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = bus.pkt_cnt[CW +: CW] == 8'd1;
        end
        checks++;
        if (!seen) $display("FAIL en_midpkt: got cnt1=%0d, required 1", bus.pkt_cnt[CW +: CW]);
        else passes++;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.grant !== 3'b000) $display("FAIL en_blocked: got grant %b, required 000", bus.grant);
        else passes++;
        bus.src_en = '1;
        expect_pkt(SRC_CFG, 3, 3, 1);
        drain(20, ok);
        checks++;
        if (!ok || bus.pkt_cnt[0 +: CW] !== 8'd1) $display("FAIL en_resume: got drained=%b cnt0=%0d, required 1 1", ok, bus.pkt_cnt[0 +: CW]);
        else passes++;
    endtask

    task automatic test_wrap_reset();
        bit ok, seen;
        logic [CW-1:0] want [3] = '{8'hFF, 8'h00, 8'hFF};
        int n_pkts [3] = '{255, 1, 255};
        do_reset();
        for (int ph = 0; ph < 3; ph++) begin
            for (int p = 0; p < n_pkts[ph]; p++) begin
                send(SRC_CFG, p, 1, 1);
                expect_pkt(SRC_CFG, p, 1, 1);
            end
            drain(2000, ok);
            checks++;
            if (!ok || bus.pkt_cnt[0 +: CW] !== want[ph]) $display("FAIL wrap_ph%0d: got drained=%b cnt0=%h, required 1 %h", ph, ok, bus.pkt_cnt[0 +: CW], want[ph]);
            else passes++;
        end
        tr_mode = 2;
        send(SRC_CFG, 9, 6, 1);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = occ == 2;
        end
        checks++;
        if (!seen || {bus.tx_valid, bus.src_ready[0]} !== 2'b10) $display("FAIL rst_busy: got full=%b v/rdy=%b%b, required 1 10", seen, bus.tx_valid, bus.src_ready[0]);
        else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.tx_valid, bus.tx_last, bus.tx_src, bus.tx_data, bus.src_ready, bus.grant, bus.err_timeout} !== '0)
            $display("FAIL rst_async: got v=%b d=%h rdy=%b gnt=%b, required all 0", bus.tx_valid, bus.tx_data, bus.src_ready, bus.grant);
        else passes++;
        checks++;
        if (bus.pkt_cnt !== '0) $display("FAIL rst_async_cnt: got %h, required 0", bus.pkt_cnt);
        else passes++;
        do_reset();
    endtask

    initial begin
        bus.src_en = '1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_enable();
        test_wrap_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
